// File: rtl/ls_buffer_if.sv
// ls_buffer_if: dispatch, result-broadcast, issue and flush signals of the
// load/store buffer, bundled so the buffer and its environment share one
// port list.
//
// Handshake: a dispatch is offered by DP_valid and is taken on any rdy
// clock edge where LSB_full was low in the previous cycle. The buffer
// issues by pulsing ALS_input_valid for one cycle, and only in a cycle
// where ALS_enable is high. Both broadcast buses are fire-and-forget
// valid-only buses.
`timescale 1ns/1ps
interface ls_buffer_if;
  logic        DP_valid;
  logic [5:0]  DP_OP_ID;
  logic [31:0] DP_inst_pc;
  logic        DP_rs1_ready;
  logic [31:0] DP_rs1_value;
  logic [3:0]  DP_rs1_tag;
  logic        DP_rs2_ready;
  logic [31:0] DP_rs2_value;
  logic [3:0]  DP_rs2_tag;
  logic [31:0] DP_imm;
  logic [3:0]  DP_ROB_id;
  logic        LSB_full;

  logic        ALU_cdb_valid;
  logic [3:0]  ALU_cdb_ROB_id;
  logic [31:0] ALU_cdb_value;
  logic        LS_cdb_valid;
  logic [3:0]  LS_cdb_ROB_id;
  logic [31:0] LS_cdb_value;

  logic        ALS_enable;
  logic        ALS_input_valid;
  logic [5:0]  ALS_OP_ID;
  logic [31:0] ALS_inst_pc;
  logic [31:0] ALS_reg_rs1;
  logic [31:0] ALS_reg_rs2;
  logic [31:0] ALS_imm;
  logic [3:0]  ALS_ROB_id;

  logic        ROB_roll_back_flag;

  // Environment side: dispatcher, broadcast buses, ALU_LS and ROB.
  modport master (
    output DP_valid, DP_OP_ID, DP_inst_pc, DP_rs1_ready, DP_rs1_value,
           DP_rs1_tag, DP_rs2_ready, DP_rs2_value, DP_rs2_tag, DP_imm,
           DP_ROB_id,
    output ALU_cdb_valid, ALU_cdb_ROB_id, ALU_cdb_value,
           LS_cdb_valid, LS_cdb_ROB_id, LS_cdb_value,
    output ALS_enable, ROB_roll_back_flag,
    input  LSB_full, ALS_input_valid, ALS_OP_ID, ALS_inst_pc,
           ALS_reg_rs1, ALS_reg_rs2, ALS_imm, ALS_ROB_id
  );

  // Buffer side.
  modport slave (
    input  DP_valid, DP_OP_ID, DP_inst_pc, DP_rs1_ready, DP_rs1_value,
           DP_rs1_tag, DP_rs2_ready, DP_rs2_value, DP_rs2_tag, DP_imm,
           DP_ROB_id,
    input  ALU_cdb_valid, ALU_cdb_ROB_id, ALU_cdb_value,
           LS_cdb_valid, LS_cdb_ROB_id, LS_cdb_value,
    input  ALS_enable, ROB_roll_back_flag,
    output LSB_full, ALS_input_valid, ALS_OP_ID, ALS_inst_pc,
           ALS_reg_rs1, ALS_reg_rs2, ALS_imm, ALS_ROB_id
  );
endinterface

// File: rtl/ls_buffer.sv
// ls_buffer: in-order load/store queue between dispatch and ALU_LS.
// Entries snoop both result broadcast buses for missing operands. The head
// issues once both of its operands are ready, ALU_LS is enabled and the
// post-issue cooldown has expired. A ROB roll-back clears the whole queue.
//
// Optional macro LSB_ISSUE_BYPASS_EN: when it is defined, the head may
// issue in the same cycle a broadcast supplies its last missing operand,
// and the broadcast value is forwarded straight onto ALS_reg_rs1/rs2.
//
// The dbg_* outputs expose the queue pointers, the occupancy and the
// cooldown counter.
`timescale 1ns/1ps
module ls_buffer #(
  parameter int LSB_SIZE_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  ls_buffer_if.slave               bus,
  output logic [LSB_SIZE_LOG2:0]   dbg_count_o,
  output logic [LSB_SIZE_LOG2-1:0] dbg_head_o,
  output logic [LSB_SIZE_LOG2-1:0] dbg_tail_o,
  output logic [1:0]               dbg_cooldown_o
);
  localparam int DEPTH = 1 << LSB_SIZE_LOG2;

  typedef logic [LSB_SIZE_LOG2-1:0] idx_t;
  typedef logic [LSB_SIZE_LOG2:0]   cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  typedef struct packed {
    logic        busy;
    logic [5:0]  op;
    logic [31:0] pc;
    logic        rs1_rdy;
    logic [31:0] rs1_val;
    logic [3:0]  rs1_tag;
    logic        rs2_rdy;
    logic [31:0] rs2_val;
    logic [3:0]  rs2_tag;
    logic [31:0] imm;
    logic [3:0]  rob;
  } entry_t;

  entry_t      ent_q [DEPTH];
  entry_t      ent_d [DEPTH];
  idx_t        head_q, head_d;
  idx_t        tail_q, tail_d;
  cnt_t        count_q, count_d;
  logic [1:0]  cooldown_q, cooldown_d;

  logic        als_valid_q, als_valid_d;
  logic [5:0]  als_op_q, als_op_d;
  logic [31:0] als_pc_q, als_pc_d;
  logic [31:0] als_rs1_q, als_rs1_d;
  logic [31:0] als_rs2_q, als_rs2_d;
  logic [31:0] als_imm_q, als_imm_d;
  logic [3:0]  als_rob_q, als_rob_d;

  logic        alu_v, ls_v;
  logic [3:0]  alu_id, ls_id;
  logic [31:0] alu_val, ls_val;

  assign alu_v   = bus.ALU_cdb_valid;
  assign alu_id  = bus.ALU_cdb_ROB_id;
  assign alu_val = bus.ALU_cdb_value;
  assign ls_v    = bus.LS_cdb_valid;
  assign ls_id   = bus.LS_cdb_ROB_id;
  assign ls_val  = bus.LS_cdb_value;

  // True when either broadcast bus carries the result for this tag.
  function automatic logic snoop_hit(input logic [3:0] tag);
    return (alu_v && alu_id == tag) || (ls_v && ls_id == tag);
  endfunction

  // Broadcast value for this tag; the ALU bus wins when both match.
  function automatic logic [31:0] snoop_val(input logic [3:0] tag);
    return (alu_v && alu_id == tag) ? alu_val : ls_val;
  endfunction

  entry_t      head_e;
  logic        h_rs1_ok, h_rs2_ok;
  logic [31:0] h_rs1_val, h_rs2_val;
  logic        issue_go, dp_go;

  assign head_e = ent_q[head_q];

`ifdef LSB_ISSUE_BYPASS_EN
  // A broadcast arriving this cycle counts as ready for the head.
  assign h_rs1_ok  = head_e.rs1_rdy || snoop_hit(head_e.rs1_tag);
  assign h_rs2_ok  = head_e.rs2_rdy || snoop_hit(head_e.rs2_tag);
  assign h_rs1_val = head_e.rs1_rdy ? head_e.rs1_val : snoop_val(head_e.rs1_tag);
  assign h_rs2_val = head_e.rs2_rdy ? head_e.rs2_val : snoop_val(head_e.rs2_tag);
`else
  // Operands must already sit in the entry before the head can issue.
  assign h_rs1_ok  = head_e.rs1_rdy;
  assign h_rs2_ok  = head_e.rs2_rdy;
  assign h_rs1_val = head_e.rs1_val;
  assign h_rs2_val = head_e.rs2_val;
`endif

  assign issue_go = head_e.busy && h_rs1_ok && h_rs2_ok && bus.ALS_enable &&
                    (cooldown_q == 2'd0);
  // A dispatch into a completely full queue is a protocol error; drop it.
  assign dp_go    = bus.DP_valid && (count_q != DEPTH_C);

  // Next state: operand capture, dispatch at tail, issue from head.
  always_comb begin
    ent_d       = ent_q;
    head_d      = head_q;
    tail_d      = tail_q;
    cooldown_d  = cooldown_q;
    als_valid_d = 1'b0;
    als_op_d    = als_op_q;
    als_pc_d    = als_pc_q;
    als_rs1_d   = als_rs1_q;
    als_rs2_d   = als_rs2_q;
    als_imm_d   = als_imm_q;
    als_rob_d   = als_rob_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].busy && !ent_q[i].rs1_rdy && snoop_hit(ent_q[i].rs1_tag)) begin
        ent_d[i].rs1_rdy = 1'b1;
        ent_d[i].rs1_val = snoop_val(ent_q[i].rs1_tag);
      end
      if (ent_q[i].busy && !ent_q[i].rs2_rdy && snoop_hit(ent_q[i].rs2_tag)) begin
        ent_d[i].rs2_rdy = 1'b1;
        ent_d[i].rs2_val = snoop_val(ent_q[i].rs2_tag);
      end
    end

    if (dp_go) begin
      ent_d[tail_q].busy    = 1'b1;
      ent_d[tail_q].op      = bus.DP_OP_ID;
      ent_d[tail_q].pc      = bus.DP_inst_pc;
      ent_d[tail_q].rs1_tag = bus.DP_rs1_tag;
      ent_d[tail_q].rs2_tag = bus.DP_rs2_tag;
      ent_d[tail_q].imm     = bus.DP_imm;
      ent_d[tail_q].rob     = bus.DP_ROB_id;
      ent_d[tail_q].rs1_rdy = bus.DP_rs1_ready || snoop_hit(bus.DP_rs1_tag);
      ent_d[tail_q].rs1_val = bus.DP_rs1_ready ? bus.DP_rs1_value
                                               : snoop_val(bus.DP_rs1_tag);
      ent_d[tail_q].rs2_rdy = bus.DP_rs2_ready || snoop_hit(bus.DP_rs2_tag);
      ent_d[tail_q].rs2_val = bus.DP_rs2_ready ? bus.DP_rs2_value
                                               : snoop_val(bus.DP_rs2_tag);
      tail_d = tail_q + idx_t'(1);
    end

    if (issue_go) begin
      ent_d[head_q].busy = 1'b0;
      head_d      = head_q + idx_t'(1);
      als_valid_d = 1'b1;
      als_op_d    = head_e.op;
      als_pc_d    = head_e.pc;
      als_rs1_d   = h_rs1_val;
      als_rs2_d   = h_rs2_val;
      als_imm_d   = head_e.imm;
      als_rob_d   = head_e.rob;
      // ALU_LS sees its enable one cycle late, so hold off two more cycles.
      cooldown_d  = 2'd2;
    end else if (cooldown_q != 2'd0) begin
      cooldown_d  = cooldown_q - 2'd1;
    end

    count_d = count_q + {{LSB_SIZE_LOG2{1'b0}}, dp_go}
                      - {{LSB_SIZE_LOG2{1'b0}}, issue_go};
  end

  // State update: reset or roll-back clears, rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst || (rdy && bus.ROB_roll_back_flag)) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      cooldown_q  <= '0;
      als_valid_q <= 1'b0;
      als_op_q    <= '0;
      als_pc_q    <= '0;
      als_rs1_q   <= '0;
      als_rs2_q   <= '0;
      als_imm_q   <= '0;
      als_rob_q   <= '0;
    end else if (rdy) begin
      ent_q       <= ent_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      cooldown_q  <= cooldown_d;
      als_valid_q <= als_valid_d;
      als_op_q    <= als_op_d;
      als_pc_q    <= als_pc_d;
      als_rs1_q   <= als_rs1_d;
      als_rs2_q   <= als_rs2_d;
      als_imm_q   <= als_imm_d;
      als_rob_q   <= als_rob_d;
    end
  end

  // One slot of slack so a registered dispatcher never overruns.
  assign bus.LSB_full        = (count_q >= DEPTH_C - cnt_t'(1));
  assign bus.ALS_input_valid = als_valid_q;
  assign bus.ALS_OP_ID       = als_op_q;
  assign bus.ALS_inst_pc     = als_pc_q;
  assign bus.ALS_reg_rs1     = als_rs1_q;
  assign bus.ALS_reg_rs2     = als_rs2_q;
  assign bus.ALS_imm         = als_imm_q;
  assign bus.ALS_ROB_id      = als_rob_q;

  assign dbg_count_o    = count_q;
  assign dbg_head_o     = head_q;
  assign dbg_tail_o     = tail_q;
  assign dbg_cooldown_o = cooldown_q;
endmodule

// File: tb/tb_ls_buffer.sv
// tb_ls_buffer: directed bench for ls_buffer. It covers reset, dispatch and
// issue, operand capture from the broadcast buses, ALU priority, in-order
// blocking, back-pressure and the full flag, roll-back and freeze.
`timescale 1ns/1ps
module tb_ls_buffer;
  logic       clk = 1'b0;
  logic       rst;
  logic       rdy;
  logic [4:0] dbg_count;
  logic [3:0] dbg_head;
  logic [3:0] dbg_tail;
  logic [1:0] dbg_cd;

  int n_asserts = 0;
  int n_fails   = 0;

  logic [3:0] exp_q[$];

  localparam logic [5:0] OP_LB = 6'd1;
  localparam logic [5:0] OP_LW = 6'd3;
  localparam logic [5:0] OP_SW = 6'd12;

  ls_buffer_if bus();

  ls_buffer #(.LSB_SIZE_LOG2(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .bus            (bus),
    .dbg_count_o    (dbg_count),
    .dbg_head_o     (dbg_head),
    .dbg_tail_o     (dbg_tail),
    .dbg_cooldown_o (dbg_cd)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.DP_valid           = 1'b0;
    bus.ALU_cdb_valid      = 1'b0;
    bus.LS_cdb_valid       = 1'b0;
    bus.ROB_roll_back_flag = 1'b0;
  endtask

  task automatic dispatch(input logic [5:0] op, input logic [31:0] pc,
                          input logic r1r, input logic [31:0] r1v, input logic [3:0] r1t,
                          input logic r2r, input logic [31:0] r2v, input logic [3:0] r2t,
                          input logic [31:0] imm, input logic [3:0] rob);
    bus.DP_valid     = 1'b1;
    bus.DP_OP_ID     = op;
    bus.DP_inst_pc   = pc;
    bus.DP_rs1_ready = r1r;
    bus.DP_rs1_value = r1v;
    bus.DP_rs1_tag   = r1t;
    bus.DP_rs2_ready = r2r;
    bus.DP_rs2_value = r2v;
    bus.DP_rs2_tag   = r2t;
    bus.DP_imm       = imm;
    bus.DP_ROB_id    = rob;
  endtask

  // Tick until an issue pulse appears or the budget runs out.
  task automatic wait_issue(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.ALS_input_valid && n < budget);
    chk("issue_timeout", bus.ALS_input_valid, 1);
  endtask

  initial begin
    int n;
    logic [3:0] e;

    rst = 1'b1;
    rdy = 1'b1;
    idle();
    bus.ALS_enable = 1'b0;
    dispatch(6'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.DP_valid       = 1'b0;
    bus.ALU_cdb_ROB_id = '0;
    bus.ALU_cdb_value  = '0;
    bus.LS_cdb_ROB_id  = '0;
    bus.LS_cdb_value   = '0;

    // Reset state.
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", bus.ALS_input_valid, 0);
    chk("rst_rs1",   bus.ALS_reg_rs1, 0);
    chk("rst_rs2",   bus.ALS_reg_rs2, 0);
    chk("rst_imm",   bus.ALS_imm, 0);
    chk("rst_rob",   bus.ALS_ROB_id, 0);
    chk("rst_op",    bus.ALS_OP_ID, 0);
    chk("rst_pc",    bus.ALS_inst_pc, 0);
    chk("rst_full",  bus.LSB_full, 0);
    chk("rst_count", dbg_count, 0);

    // Ready LW issues on the edge after it is written.
    dispatch(OP_LW, 32'h100, 1, 32'h1000, 0, 1, 0, 0, 32'd4, 4'd3);
    bus.ALS_enable = 1'b1;
    tick();
    idle();
    chk("t1_no_early", bus.ALS_input_valid, 0);
    chk("t1_count1", dbg_count, 1);
    tick();
    chk("t1_valid", bus.ALS_input_valid, 1);
    chk("t1_rs1",   bus.ALS_reg_rs1, 32'h1000);
    chk("t1_imm",   bus.ALS_imm, 4);
    chk("t1_rob",   bus.ALS_ROB_id, 3);
    chk("t1_op",    bus.ALS_OP_ID, OP_LW);
    chk("t1_pc",    bus.ALS_inst_pc, 32'h100);
    chk("t1_count0", dbg_count, 0);
    tick();
    chk("t1_pulse", bus.ALS_input_valid, 0);
    chk("t1_cd1",   dbg_cd, 1);
    tick();

    // SW waits on tag 5, which arrives on the ALU bus.
    dispatch(OP_SW, 32'h104, 0, 0, 4'd5, 1, 32'hDEAD, 0, 32'd8, 4'd4);
    tick();
    idle();
    tick();
    chk("t2_wait", bus.ALS_input_valid, 0);
    bus.ALU_cdb_valid  = 1'b1;
    bus.ALU_cdb_ROB_id = 4'd5;
    bus.ALU_cdb_value  = 32'h2000;
    tick();
    idle();
`ifndef LSB_ISSUE_BYPASS_EN
    chk("t2_not_t1", bus.ALS_input_valid, 0);
    tick();
`endif
    chk("t2_valid", bus.ALS_input_valid, 1);
    chk("t2_rs1",   bus.ALS_reg_rs1, 32'h2000);
    chk("t2_rs2",   bus.ALS_reg_rs2, 32'hDEAD);
    chk("t2_rob",   bus.ALS_ROB_id, 4);
    chk("t2_op",    bus.ALS_OP_ID, OP_SW);
    tick();
    tick();

    // Same-cycle dispatch capture: both buses match, ALU value wins.
    dispatch(OP_LW, 32'h108, 0, 0, 4'd9, 1, 0, 0, 0, 4'd6);
    bus.ALU_cdb_valid  = 1'b1;
    bus.ALU_cdb_ROB_id = 4'd9;
    bus.ALU_cdb_value  = 32'hAAAA;
    bus.LS_cdb_valid   = 1'b1;
    bus.LS_cdb_ROB_id  = 4'd9;
    bus.LS_cdb_value   = 32'hBBBB;
    tick();
    idle();
    tick();
    chk("t3_valid", bus.ALS_input_valid, 1);
    chk("t3_rs1",   bus.ALS_reg_rs1, 32'hAAAA);
    tick();
    tick();

    // A waiting head LB blocks the younger, fully ready SW.
    dispatch(OP_LB, 32'h10C, 0, 0, 4'd7, 1, 0, 0, 0, 4'd8);
    tick();
    dispatch(OP_SW, 32'h110, 1, 32'h3000, 0, 1, 32'h55, 0, 0, 4'd9);
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_blocked", bus.ALS_input_valid, 0);
    end
    chk("t4_count2", dbg_count, 2);
    bus.LS_cdb_valid  = 1'b1;
    bus.LS_cdb_ROB_id = 4'd7;
    bus.LS_cdb_value  = 32'h4000;
    tick();
    idle();
`ifndef LSB_ISSUE_BYPASS_EN
    chk("t4_not_t1", bus.ALS_input_valid, 0);
    tick();
`endif
    chk("t4_lb_valid", bus.ALS_input_valid, 1);
    chk("t4_lb_rob",   bus.ALS_ROB_id, 8);
    chk("t4_lb_rs1",   bus.ALS_reg_rs1, 32'h4000);
    chk("t4_lb_op",    bus.ALS_OP_ID, OP_LB);
    tick();
    chk("t4_cool1", bus.ALS_input_valid, 0);
    tick();
    chk("t4_cool2", bus.ALS_input_valid, 0);
    tick();
    chk("t4_sw_valid", bus.ALS_input_valid, 1);
    chk("t4_sw_rob",   bus.ALS_ROB_id, 9);
    chk("t4_sw_rs1",   bus.ALS_reg_rs1, 32'h3000);
    chk("t4_sw_rs2",   bus.ALS_reg_rs2, 32'h55);

    // Back-pressure: fill 16 entries, 17th dropped, then drain in order.
    bus.ALS_enable = 1'b0;
    tick();
    tick();
    chk("t5_empty", dbg_count, 0);
    chk("t5_head5", dbg_head, 5);
    for (int i = 0; i < 16; i++) begin
      dispatch(OP_LW, 32'h200 + 32'(4 * i), 1, 32'h100 + 32'(i), 0, 1, 0, 0, 0, 4'(i));
      exp_q.push_back(4'(i));
      tick();
      chk("t5_count", dbg_count, 32'(i + 1));
      chk("t5_full",  bus.LSB_full, (i + 1 >= 15));
    end
    dispatch(OP_LW, 32'h2FC, 1, 32'hBAD, 0, 1, 0, 0, 0, 4'hE);
    tick();
    idle();
    chk("t5_drop_count", dbg_count, 16);
    chk("t5_drop_full",  bus.LSB_full, 1);
    bus.ALS_enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      wait_issue(8, n);
      e = exp_q.pop_front();
      chk("t5_rob",  bus.ALS_ROB_id, e);
      chk("t5_rs1",  bus.ALS_reg_rs1, 32'h100 + 32'(e));
      chk("t5_head", dbg_head, 32'((6 + k) % 16));
      if (k > 0) chk("t5_gap_ge3", (n >= 3), 1);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_extra", bus.ALS_input_valid, 0);
    end
    chk("t5_drained", dbg_count, 0);

    // Roll-back with a same-cycle dispatch, broadcast and possible issue.
    bus.ALS_enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      dispatch(OP_SW, 32'h400 + 32'(4 * i), 1, 32'h500 + 32'(i), 0, 1, 32'(i), 0, 0, 4'(i));
      tick();
    end
    idle();
    chk("t6_count6", dbg_count, 6);
    tick();
    dispatch(OP_LW, 32'h480, 1, 32'h1234, 0, 1, 0, 0, 0, 4'd12);
    bus.ALU_cdb_valid      = 1'b1;
    bus.ALU_cdb_ROB_id     = 4'd1;
    bus.ALU_cdb_value      = 32'h9999;
    bus.ROB_roll_back_flag = 1'b1;
    bus.ALS_enable         = 1'b1;
    tick();
    idle();
    chk("t6_count0", dbg_count, 0);
    chk("t6_valid0", bus.ALS_input_valid, 0);
    chk("t6_head0",  dbg_head, 0);
    chk("t6_tail0",  dbg_tail, 0);
    chk("t6_full0",  bus.LSB_full, 0);
    chk("t6_rs1_0",  bus.ALS_reg_rs1, 0);
    chk("t6_cd0",    dbg_cd, 0);
    dispatch(OP_LW, 32'h300, 1, 32'h7777, 0, 1, 0, 0, 0, 4'd2);
    tick();
    idle();
    chk("t6_tail1",  dbg_tail, 1);
    chk("t6_count1", dbg_count, 1);
    tick();
    chk("t6_valid", bus.ALS_input_valid, 1);
    chk("t6_rs1",   bus.ALS_reg_rs1, 32'h7777);
    chk("t6_rob",   bus.ALS_ROB_id, 2);
    chk("t6_head1", dbg_head, 1);

    // Freeze mid-issue for three cycles, then resume.
    bus.ALS_enable = 1'b0;
    tick();
    tick();
    dispatch(OP_LW, 32'h500, 1, 32'hA0A0, 0, 1, 0, 0, 0, 4'd10);
    tick();
    dispatch(OP_LW, 32'h504, 1, 32'hB0B0, 0, 1, 0, 0, 0, 4'd11);
    tick();
    idle();
    bus.ALS_enable = 1'b1;
    tick();
    chk("t7_valid", bus.ALS_input_valid, 1);
    chk("t7_rob",   bus.ALS_ROB_id, 10);
    chk("t7_cd2",   dbg_cd, 2);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t7_hold_valid", bus.ALS_input_valid, 1);
      chk("t7_hold_cd",    dbg_cd, 2);
      chk("t7_hold_rob",   bus.ALS_ROB_id, 10);
      chk("t7_hold_count", dbg_count, 1);
    end
    rdy = 1'b1;
    tick();
    chk("t7_res_valid1", bus.ALS_input_valid, 0);
    chk("t7_res_cd1",    dbg_cd, 1);
    tick();
    chk("t7_res_valid2", bus.ALS_input_valid, 0);
    chk("t7_res_cd0",    dbg_cd, 0);
    tick();
    chk("t7_next_valid", bus.ALS_input_valid, 1);
    chk("t7_next_rob",   bus.ALS_ROB_id, 11);
    chk("t7_next_rs1",   bus.ALS_reg_rs1, 32'hB0B0);
    chk("t7_count0",     dbg_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end
endmodule

// File: doc/ls_buffer.md
Name: ls_buffer

Overview:
- In-order load/store queue between the dispatcher and the ALU_LS execution stage.
- Accepts one memory op per cycle from dispatch and captures missing operands from the two result broadcast buses (arithmetic ALU, ALU_LS).
- Issues the queue head to ALU_LS once both operands are ready and ALU_LS signals it can accept.
- Flushed by ROB roll-back.

Parameters:
LSB_SIZE_LOG2, 4, log2 of queue depth (16 entries)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
rdy  in  1  global ready; low = freeze all state
DP_valid  in  1  dispatch op present
DP_OP_ID  in  6  op id (LB..SW encodings)
DP_inst_pc  in  32  instruction pc
DP_rs1_ready  in  1  rs1 value valid
DP_rs1_value  in  32  rs1 value
DP_rs1_tag  in  4  ROB id producing rs1 (when not ready)
DP_rs2_ready  in  1  rs2 value valid; dispatcher drives 1 for loads
DP_rs2_value  in  32  rs2 value
DP_rs2_tag  in  4  ROB id producing rs2
DP_imm  in  32  sign-extended offset
DP_ROB_id  in  4  destination ROB id
LSB_full  out  1  queue cannot take a new op next cycle
ALU_cdb_valid  in  1  arithmetic result broadcast
ALU_cdb_ROB_id  in  4  its ROB id
ALU_cdb_value  in  32  its value
LS_cdb_valid  in  1  ALU_LS result broadcast
LS_cdb_ROB_id  in  4  its ROB id
LS_cdb_value  in  32  its value
ALS_enable  in  1  ALU_LS can accept
ALS_input_valid  out  1  issue pulse
ALS_OP_ID  out  6  issued op id
ALS_inst_pc  out  32  issued pc
ALS_reg_rs1  out  32  issued rs1 value
ALS_reg_rs2  out  32  issued rs2 value
ALS_imm  out  32  issued imm
ALS_ROB_id  out  4  issued ROB id
ROB_roll_back_flag  in  1  flush

Behaviour:
- **Reset:**
  - head = tail = count = 0; all entry busy bits 0.
  - cooldown = 0.
  - ALS_input_valid = 0; all ALS_* data outputs 0.
  - LSB_full = 0.
- **rdy = 0:** every register, including ALS_* outputs, holds its value.
- **Priority:** rst > !rdy > roll-back > normal operation.
- **Roll-back:**
  - Same effect as reset, applied on that edge.
  - Any dispatch and CDB input in that cycle is discarded.
- **Full flag:**
  - LSB_full = (count >= 2^LSB_SIZE_LOG2 - 1), combinational from the registered count.
  - This gives one slot of slack for a registered dispatcher.
  - A dispatch arriving with count == depth is dropped (protocol violation); count never exceeds depth.
- **Dispatch (DP_valid):**
  - Entry written at tail; tail wraps modulo depth.
  - If a CDB bus is valid in the same cycle with ROB_id matching a not-ready source tag, the entry stores that value with ready = 1.
  - If both buses match the same tag, the ALU bus wins.
- **Capture (every cycle):**
  - Each busy entry with a not-ready source whose tag equals a valid CDB ROB_id latches the value and sets ready.
  - Both sources of one entry may be captured in the same cycle.
- **Issue condition:** head busy && rs1 ready && rs2 ready && ALS_enable && cooldown == 0.
- **Issue action:**
  - Register the head fields onto ALS_*; ALS_input_valid = 1 for exactly one cycle.
  - Free the head; head advances with wrap.
  - Set cooldown = 2, decremented each cycle it is nonzero. ALS_enable is registered one cycle late inside ALU_LS, so without the cooldown a second issue could hit a busy ALU_LS.
- **Ordering:** strictly in order. A non-ready head blocks all younger entries, both loads and stores.
- **Count:**
  - Simultaneous dispatch and issue: count unchanged.
  - Issue only: -1. Dispatch only: +1.
- **Data path:** values are passed unmodified; address arithmetic belongs to ALU_LS.
- **Tag/ready rule:** a tag is compared only while its ready bit is 0.

Optional Feature:
- **Macro:** LSB_ISSUE_BYPASS_EN.
- **Defined:**
  - The head may issue in the same cycle a CDB broadcast supplies its last missing operand.
  - The broadcast value is driven into ALS_reg_rs1/rs2 directly.
  - Latency from broadcast to ALS_input_valid is 1 cycle.
- **Undefined:**
  - The operand is first captured into the entry; issue happens on the following cycle or later.
  - Latency from broadcast to ALS_input_valid is 2 cycles.
- All other behaviour is identical.

Test Plan:
- **Reset:** after rst pulse, check all outputs 0 and LSB_full = 0. Then dispatch LW, rs1 ready = 0x1000, imm = 4, ROB_id = 3, ALS_enable = 1 -> ALS_input_valid on the next edge with rs1 = 0x1000, imm = 4, ROB_id = 3.
- **CDB capture (bypass off):** dispatch SW with rs1 tag 5 not ready, rs2 ready = 0xDEAD. Broadcast ALU_cdb ROB_id 5 value 0x2000 at cycle t -> ALS_input_valid at t+2 with rs1 = 0x2000, rs2 = 0xDEAD. With LSB_ISSUE_BYPASS_EN: at t+1.
- **Ordering:** head LB waiting on tag 7, younger SW fully ready -> no issue. After LS_cdb ROB_id 7 broadcast, LB issues first; SW issues no earlier than 3 cycles later (cooldown).
- **Back-pressure:** ALS_enable = 0 with 16 dispatches -> LSB_full rises when count reaches 15; 17th dispatch dropped. Raise ALS_enable -> 16 issues in order, each at least 3 cycles apart, ROB ids 0..15 wrapping head correctly.
- **Roll-back:** 6 entries queued plus a same-cycle dispatch and CDB -> next cycle count = 0 and ALS_input_valid = 0. A new dispatch then lands in entry 0.
- **Freeze:** rdy = 0 for 3 cycles mid-issue -> ALS_input_valid and cooldown hold their values. Resume continues exactly where it paused.
